// File: rtl/button_pkg.sv
// Shared state encoding and default 25 MHz timing for the push-button conditioner.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DEB_DN  = 2'd1,
    PRESSED = 2'd2,
    DEB_UP  = 2'd3
  } btn_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd250000;
  localparam int unsigned DEF_LONG_CYCLES     = 32'd25000000;
  localparam int unsigned DEF_REPEAT_CYCLES   = 32'd5000000;

  // Counter width able to hold 0..limit-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 32'd2) ? 32'd1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchroniser for an asynchronous single-bit input pin.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_d;
  logic meta_q;
  logic sync_d;
  logic sync_q;

  // Next value of each stage of the chain.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Both stages start at RST_VAL so an idle pin produces no spurious edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/button_debounce.sv
// Debounces the active-low button pin and emits press/release/long/repeat pulses.
module button_debounce
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int unsigned DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned HW = cnt_width(LONG_CYCLES);
  localparam int unsigned RW = cnt_width(REPEAT_CYCLES);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [DW-1:0] DEB_ONE   = DW'(32'd1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 32'd1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(32'd1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 32'd1);
  localparam logic [RW-1:0] REP_ONE   = RW'(32'd1);

  if ((DEBOUNCE_CYCLES < 32'd2) || (LONG_CYCLES < 32'd2) || (REPEAT_CYCLES < 32'd2)) begin : g_bad_param
    $error("button_debounce: every timing parameter must be at least 2");
  end

  logic btn_sync_s;
  logic down_s;

  btn_state_e    state_d,     state_q;
  logic [DW-1:0] deb_cnt_d,   deb_cnt_q;
  logic [HW-1:0] hold_cnt_d,  hold_cnt_q;
  logic [RW-1:0] rep_cnt_d,   rep_cnt_q;
  logic          long_done_d, long_done_q;
  logic          pressed_d,   pressed_q;
  logic          press_d,     press_q;
  logic          release_d,   release_q;
  logic          long_d,      long_q;
  logic          repeat_d,    repeat_q;

  logic          hold_active_s;
  logic [HW-1:0] hold_step_s;
  logic [RW-1:0] rep_step_s;
  logic          long_fire_s;
  logic          rep_fire_s;

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_n),
    .q     (btn_sync_s)
  );

  assign down_s = ~btn_sync_s;

  // One step of the hold timer: count up to the long threshold, then pace repeats.
  always_comb begin
    hold_step_s = hold_cnt_q;
    rep_step_s  = rep_cnt_q;
    long_fire_s = 1'b0;
    rep_fire_s  = 1'b0;
    if (hold_cnt_q != HOLD_LAST) begin
      hold_step_s = hold_cnt_q + HOLD_ONE;
    end else if (!long_done_q) begin
      long_fire_s = 1'b1;
      rep_step_s  = '0;
    end else if (rep_cnt_q == REP_LAST) begin
      rep_fire_s = 1'b1;
      rep_step_s = '0;
    end else begin
      rep_step_s = rep_cnt_q + REP_ONE;
    end
  end

  // Debounce state machine; the release edge clears hold state so it wins over a repeat.
  always_comb begin
    state_d       = state_q;
    deb_cnt_d     = deb_cnt_q;
    hold_cnt_d    = hold_cnt_q;
    rep_cnt_d     = rep_cnt_q;
    long_done_d   = long_done_q;
    pressed_d     = pressed_q;
    press_d       = 1'b0;
    release_d     = 1'b0;
    long_d        = 1'b0;
    repeat_d      = 1'b0;
    hold_active_s = 1'b0;
    case (state_q)
      IDLE: begin
        pressed_d = 1'b0;
        if (down_s) begin
          state_d   = DEB_DN;
          deb_cnt_d = DEB_ONE;
        end else begin
          deb_cnt_d = '0;
        end
      end
      DEB_DN: begin
        pressed_d = 1'b0;
        if (!down_s) begin
          state_d   = IDLE;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d     = PRESSED;
          press_d     = 1'b1;
          pressed_d   = 1'b1;
          deb_cnt_d   = '0;
          hold_cnt_d  = '0;
          rep_cnt_d   = '0;
          long_done_d = 1'b0;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_ONE;
        end
      end
      PRESSED: begin
        pressed_d     = 1'b1;
        hold_active_s = 1'b1;
        if (!down_s) begin
          state_d   = DEB_UP;
          deb_cnt_d = DEB_ONE;
        end else begin
          state_d = PRESSED;
        end
      end
      DEB_UP: begin
        pressed_d = 1'b1;
        if (down_s) begin
          state_d       = PRESSED;
          hold_active_s = 1'b1;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d     = IDLE;
          release_d   = 1'b1;
          pressed_d   = 1'b0;
          deb_cnt_d   = '0;
          hold_cnt_d  = '0;
          rep_cnt_d   = '0;
          long_done_d = 1'b0;
        end else begin
          deb_cnt_d     = deb_cnt_q + DEB_ONE;
          hold_active_s = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        deb_cnt_d   = '0;
        hold_cnt_d  = '0;
        rep_cnt_d   = '0;
        long_done_d = 1'b0;
        pressed_d   = 1'b0;
      end
    endcase
    if (hold_active_s) begin
      hold_cnt_d  = hold_step_s;
      rep_cnt_d   = rep_step_s;
      long_done_d = long_done_q | long_fire_s;
      long_d      = long_fire_s;
      repeat_d    = rep_fire_s;
    end else begin
      long_d   = 1'b0;
      repeat_d = 1'b0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      deb_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      rep_cnt_q   <= '0;
      long_done_q <= 1'b0;
      pressed_q   <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      repeat_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      long_done_q <= long_done_d;
      pressed_q   <= pressed_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      repeat_q    <= repeat_d;
    end
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_button_debounce.sv
// Directed plus random bench for button_debounce against a window/elapsed-time reference model.
module tb_button_debounce;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int REP  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic btn_n = 1'b1;
  logic pressed, press_pulse, release_pulse, long_pulse, repeat_pulse;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: debounced level flips when the last DEB "down" samples all disagree with it.
  bit m_level;
  int m_press_at;
  bit hist[$];
  bit win[$];
  bit e_press, e_release, e_long, e_repeat;

  int n_press, n_release, n_long, n_repeat;
  int last_press, last_release, last_long;
  int rep_at[$];

  button_debounce #(
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LONG),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_n         (btn_n),
    .pressed       (pressed),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse)
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic got, input logic want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, got, want);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, got, want);
    end
  endtask

  task automatic model_reset();
    m_level = 1'b0;
    hist = '{1'b1, 1'b1};
    win.delete();
    for (int i = 0; i < DEB; i++) win.push_back(1'b0);
    e_press = 1'b0; e_release = 1'b0; e_long = 1'b0; e_repeat = 1'b0;
  endtask

  task automatic model_edge(input bit b);
    bit d;
    bit flip;
    int el;
    hist.push_back(b);
    d = ~hist[0];
    void'(hist.pop_front());
    win.push_back(d);
    void'(win.pop_front());
    flip = 1'b1;
    foreach (win[i]) if (win[i] == m_level) flip = 1'b0;
    e_press = 1'b0; e_release = 1'b0; e_long = 1'b0; e_repeat = 1'b0;
    if (flip) begin
      m_level = ~m_level;
      if (m_level) begin
        e_press    = 1'b1;
        m_press_at = cyc;
      end else begin
        e_release = 1'b1;
      end
    end else if (m_level) begin
      el       = cyc - m_press_at;
      e_long   = (el == LONG);
      e_repeat = (el > LONG) && (((el - LONG) % REP) == 0);
    end
  endtask

  task automatic compare_all();
    check_bit("pressed", pressed, m_level);
    check_bit("press_pulse", press_pulse, e_press);
    check_bit("release_pulse", release_pulse, e_release);
    check_bit("long_pulse", long_pulse, e_long);
    check_bit("repeat_pulse", repeat_pulse, e_repeat);
    check_int("one_hot", ($countones({press_pulse, release_pulse, long_pulse, repeat_pulse}) <= 1) ? 1 : 0, 1);
    if (press_pulse === 1'b1) begin n_press++; last_press = cyc; end
    if (release_pulse === 1'b1) begin n_release++; last_release = cyc; end
    if (long_pulse === 1'b1) begin n_long++; last_long = cyc; end
    if (repeat_pulse === 1'b1) begin n_repeat++; rep_at.push_back(cyc); end
  endtask

  task automatic drive(input logic b);
    @(negedge clk);
    btn_n = b;
    @(posedge clk);
    cyc++;
    if (rst_n) model_edge(b);
    else model_reset();
    #1;
    compare_all();
  endtask

  function automatic int pulses();
    return n_press + n_release + n_long + n_repeat;
  endfunction

  initial begin
    int first_low, first_high, p, p0, r0, len;
    logic lvl;
    model_reset();
    for (int i = 0; i < 3; i++) drive(1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) drive(1'b1);

    // Clean press: press is the (DEB+2)-th edge counting the first edge that samples low.
    rep_at.delete();
    p0 = n_press;
    r0 = n_release;
    first_low = cyc + 1;
    for (int i = 0; i < 10; i++) drive(1'b0);
    check_int("press_lat", last_press - first_low + 1, DEB + 2);
    check_int("press_once", n_press - p0, 1);
    // Short release bounce while held, then hold to press+60.
    drive(1'b1);
    drive(1'b1);
    for (int i = 0; i < 80 && cyc < last_press + 60; i++) drive(1'b0);
    check_int("rel_bounce_none", n_release - r0, 0);
    check_int("long_at", last_long - last_press, LONG);
    check_int("rep_count", rep_at.size(), 5);
    for (int i = 0; i < 5; i++)
      check_int("rep_at", (i < rep_at.size()) ? rep_at[i] - last_press : -1, LONG + REP * (i + 1));
    first_high = cyc + 1;
    for (int i = 0; i < 10; i++) drive(1'b1);
    check_int("release_lat", last_release - first_high + 1, DEB + 2);
    check_int("no_rep_after_rel", rep_at.size(), 5);

    // Press bounce: runs of 3 never qualify.
    p0 = n_press;
    for (int i = 0; i < 3; i++) drive(1'b0);
    drive(1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0);
    for (int i = 0; i < 8; i++) drive(1'b1);
    check_int("bounce_no_press", n_press - p0, 0);
    first_low = cyc + 1;
    for (int i = 0; i < 10; i++) drive(1'b0);
    check_int("press_lat_bounce", last_press - first_low + 1, DEB + 2);
    for (int i = 0; i < 10; i++) drive(1'b1);

    // Release lands exactly on the second repeat boundary.
    rep_at.delete();
    first_low = cyc + 1;
    for (int i = 0; i < 6; i++) drive(1'b0);
    p = last_press;
    check_int("press_lat_coin", p - first_low + 1, DEB + 2);
    for (int i = 0; i < 40 && cyc < p + 30; i++) drive(1'b0);
    for (int i = 0; i < 12; i++) drive(1'b1);
    check_int("coin_release_at", last_release - p, LONG + 2 * REP);
    check_int("coin_rep_count", rep_at.size(), 1);
    check_int("coin_rep_at", (rep_at.size() > 0) ? rep_at[0] - p : -1, LONG + REP);

    // Asynchronous reset while held.
    for (int i = 0; i < 8; i++) drive(1'b0);
    check_bit("held_before_rst", pressed, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_bit("rst_pressed", pressed, 1'b0);
    check_bit("rst_press", press_pulse, 1'b0);
    check_bit("rst_release", release_pulse, 1'b0);
    check_bit("rst_long", long_pulse, 1'b0);
    check_bit("rst_repeat", repeat_pulse, 1'b0);
    model_reset();
    drive(1'b0);
    drive(1'b0);
    p0 = pulses();
    btn_n = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) drive(1'b1);
    check_int("post_reset_quiet", pulses() - p0, 0);

    // Random bouncing with occasional long holds.
    lvl = 1'b1;
    for (int k = 0; k < 60; k++) begin
      lvl = ~lvl;
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 45)) : int'($urandom_range(1, 6));
      for (int j = 0; j < len; j++) drive(lvl);
    end
    for (int i = 0; i < 10; i++) drive(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
